cache_fill_fsm: RTL and testbench

Parametrised cache-miss fill controller for the next-generation pipelined core, replacing the single-cycle `memory1c` path with caches backed by a multi-cycle, pipelined main memory. On a miss it streams a full block from main memory into the cache data array and then writes the tag. It holds `fsm_busy` high so the hazard unit stalls the pipeline for the whole fill. One instance serves the I-cache and one serves the D-cache.

---
 rtl/cache_pkg.sv | 13 +
 rtl/cache_fill_counter.sv | 20 ++
 rtl/cache_fill_fsm.sv | 88 ++++++++
 tb/tb_cache_fill_fsm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared state type, constants and width helper for the cache fill controller
package cache_pkg;
  typedef enum logic {IDLE, FILL} fill_state_t;
  localparam int WORD_BYTES = 2;
  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int DEF_MEM_LATENCY = 4;
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/cache_fill_counter.sv
// cache_fill_counter: W-bit up counter with synchronous clear and count enable
//   clk, rst : clock and synchronous active-high reset
//   i_clr    : clear to zero (wins over i_en)
//   i_en     : increment by one
//   o_cnt    : current count
module cache_fill_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + W'(1);
  assign o_cnt = r_cnt;
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: streams one cache block from pipelined main memory on a miss, then writes the tag
//   clk, rst          : clock and synchronous active-high reset
//   miss_detected     : miss request, accepted only in IDLE
//   miss_address      : byte address that missed
//   memory_data_valid : memory_data carries a returned word
//   memory_data       : returned word
//   fsm_busy          : fill in progress (pipeline stall)
//   memory_enable     : read request at memory_address this cycle
//   memory_address    : byte address of the word being requested
//   write_data_array  : write fill_data into block word word_index
//   word_index        : word offset inside the block
//   fill_data         : word to write, straight from memory_data
//   write_tag_array   : one-cycle strobe alongside the last word
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int WORD_W          = 16,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int MEM_LATENCY     = DEF_MEM_LATENCY
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  input  logic [WORD_W-1:0]                  memory_data,
  output logic                               fsm_busy,
  output logic                               memory_enable,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [log2(WORDS_PER_BLOCK)-1:0]   word_index,
  output logic [WORD_W-1:0]                  fill_data,
  output logic                               write_tag_array
);
  localparam int IDX_W = log2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(WORD_BYTES * WORDS_PER_BLOCK - 1);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("cache_fill_fsm: MEM_LATENCY must be at least 1");
  end
  if (WORDS_PER_BLOCK < 2 || (1 << IDX_W) != WORDS_PER_BLOCK) begin : g_bad_block
    $error("cache_fill_fsm: WORDS_PER_BLOCK must be a power of two >= 2");
  end

  fill_state_t       r_state, w_next;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  w_issue_cnt, w_recv_cnt;
  logic              w_fill, w_start, w_issue, w_recv, w_last;

  // Counters sit at zero throughout IDLE, so they start clean on every accepted miss
  cache_fill_counter #(.W(CNT_W)) u_issue (
    .clk(clk), .rst(rst), .i_clr(!w_fill), .i_en(w_issue), .o_cnt(w_issue_cnt)
  );
  cache_fill_counter #(.W(CNT_W)) u_recv (
    .clk(clk), .rst(rst), .i_clr(!w_fill), .i_en(w_recv), .o_cnt(w_recv_cnt)
  );

  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_base  <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) r_base <= miss_address & ~OFF_MASK;
    end

  always_comb begin
    w_fill  = r_state == FILL;
    w_start = !w_fill && miss_detected;
    w_issue = w_fill && w_issue_cnt < CNT_W'(WORDS_PER_BLOCK);
    w_recv  = w_fill && memory_data_valid;
    w_last  = w_recv && w_recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1);
    w_next  = w_start ? FILL : w_last ? IDLE : r_state;
  end

  // Address and index are forced to zero when not strobed so idle outputs read all-zero
  always_comb begin
    fsm_busy         = w_fill;
    memory_enable    = w_issue;
    memory_address   = w_issue ? r_base + ADDR_W'(w_issue_cnt) * ADDR_W'(WORD_BYTES) : '0;
    write_data_array = w_recv;
    word_index       = w_recv ? w_recv_cnt[IDX_W-1:0] : '0;
    fill_data        = memory_data;
    write_tag_array  = w_last;
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: scoreboard bench for three cache_fill_fsm configurations behind fixed-latency memory models
module tb_cache_fill_fsm;
  localparam int WPBS [3] = '{8, 4, 16};
  localparam int LATS [3] = '{4, 1, 10};
  typedef struct {int k; int cyc; logic [15:0] a;} iss_t;
  typedef struct {int k; int cyc; int idx; logic [15:0] d;} wr_t;
  typedef struct {int k; int len;} bz_t;
  logic        clk = 0;
  logic        rst = 1;
  logic [2:0]  miss = '0, mvalid = '0, stray = '0;
  logic [15:0] maddr_in [3];
  logic [15:0] mdata [3];
  logic [2:0]  busy, men, wr, tag;
  logic [15:0] maddr [3];
  logic [15:0] fdata [3];
  logic [3:0]  widx [3];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g
    localparam int IW = $clog2(WPBS[k]);
    logic [IW-1:0] wi;
    cache_fill_fsm #(.WORDS_PER_BLOCK(WPBS[k]), .MEM_LATENCY(LATS[k])) u (
      .clk(clk), .rst(rst), .miss_detected(miss[k]), .miss_address(maddr_in[k]),
      .memory_data_valid(mvalid[k]), .memory_data(mdata[k]), .fsm_busy(busy[k]),
      .memory_enable(men[k]), .memory_address(maddr[k]), .write_data_array(wr[k]),
      .word_index(wi), .fill_data(fdata[k]), .write_tag_array(tag[k])
    );
    assign widx[k] = 4'(wi);
  end
  int   n_tests = 0, n_fail = 0, cyc = 0;
  int   n_wr [3], n_tag [3], exp_tag [3], run [3];
  bit   shv [3][16];
  logic [15:0] sha [3][16];
  iss_t iq [$];
  wr_t  wq [$];
  bz_t  bq [$];
  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", t, o, e);
    end
  endtask
  function automatic logic [15:0] dat(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction
  task automatic step();
    iss_t ei;
    wr_t  ew;
    bz_t  eb;
    @(negedge clk);
    cyc++;
    for (int j = 0; j < 3; j++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) shv[j][i] = 0;
        mvalid[j] = 0;
        mdata[j]  = '0;
      end else begin
        mvalid[j] = shv[j][LATS[j]-1] | stray[j];
        mdata[j]  = stray[j] ? 16'hBEEF : shv[j][LATS[j]-1] ? dat(sha[j][LATS[j]-1]) : 16'h0;
        for (int i = 15; i > 0; i--) begin
          shv[j][i] = shv[j][i-1];
          sha[j][i] = sha[j][i-1];
        end
        shv[j][0] = men[j];
        sha[j][0] = maddr[j];
      end
    end
    #2;
    for (int j = 0; j < 3; j++) begin
      if (men[j]) begin
        chk("issue_expected", iq.size() > 0, 1'b1);
        if (iq.size() > 0) begin
          ei = iq.pop_front();
          chk("issue_inst", j, ei.k);
          chk("issue_cycle", cyc, ei.cyc);
          chk("issue_addr", maddr[j], ei.a);
        end
      end
      if (wr[j]) begin
        n_wr[j]++;
        chk("write_expected", wq.size() > 0, 1'b1);
        if (wq.size() > 0) begin
          ew = wq.pop_front();
          chk("write_inst", j, ew.k);
          chk("write_cycle", cyc, ew.cyc);
          chk("write_index", int'(widx[j]), ew.idx);
          chk("write_data", fdata[j], ew.d);
        end
      end
      if (tag[j]) begin
        n_tag[j]++;
        chk("tag_with_last", {wr[j], widx[j]}, {1'b1, 4'(WPBS[j] - 1)});
      end
      if (busy[j]) run[j]++;
      else if (run[j] > 0) begin
        if (bq.size() > 0 && bq[0].k == j) begin
          eb = bq.pop_front();
          chk("busy_length", run[j], eb.len);
        end
        run[j] = 0;
      end
    end
    #1;
  endtask
  task automatic start_fill(input int k, input logic [15:0] a);
    logic [15:0] base;
    int c;
    c    = cyc;
    base = a & ~16'(2 * WPBS[k] - 1);
    miss[k]     = 1;
    maddr_in[k] = a;
    for (int i = 0; i < WPBS[k]; i++) begin
      iq.push_back('{k, c + 1 + i, base + 16'(2 * i)});
      wq.push_back('{k, c + 1 + LATS[k] + i, i, dat(base + 16'(2 * i))});
    end
    bq.push_back('{k, WPBS[k] + LATS[k]});
    exp_tag[k]++;
    step();
    miss[k] = 0;
  endtask
  task automatic drain();
    int b;
    b = 0;
    while ((iq.size() > 0 || wq.size() > 0 || bq.size() > 0) && b < 200) begin
      step();
      b++;
    end
    chk("drain_timeout", b < 200, 1'b1);
    step();
  endtask
  task automatic check_idle(input int j);
    chk("idle_outputs", {busy[j], men[j], maddr[j], wr[j], widx[j], tag[j], fdata[j]}, 40'h0);
  endtask
  initial begin
    int c0, b;
    for (int j = 0; j < 3; j++) begin
      maddr_in[j] = '0;
      mdata[j] = '0;
      n_wr[j] = 0;
      n_tag[j] = 0;
      exp_tag[j] = 0;
      run[j] = 0;
    end
    repeat (2) begin
      step();
      for (int j = 0; j < 3; j++) check_idle(j);
    end
    rst = 0;
    repeat (3) begin
      step();
      for (int j = 0; j < 3; j++) check_idle(j);
    end
    start_fill(0, 16'h1234);
    drain();
    start_fill(0, 16'hFFF6);
    drain();
    c0 = cyc;
    start_fill(0, 16'h0100);
    step();
    miss[0] = 1;
    maddr_in[0] = 16'h4444;
    step();
    miss[0] = 0;
    while (cyc < c0 + 12) step();
    chk("tag_cycle_busy", busy[0], 1'b1);
    chk("tag_cycle_tag", tag[0], 1'b1);
    miss[0] = 1;
    maddr_in[0] = 16'h2002;
    step();
    chk("tag_cycle_miss_ignored", busy[0], 1'b0);
    start_fill(0, 16'h2002);
    drain();
    stray[0] = 1;
    step();
    chk("stray_valid_no_write", wr[0], 1'b0);
    chk("stray_valid_no_busy", busy[0], 1'b0);
    stray[0] = 0;
    step();
    start_fill(0, 16'h0A00);
    drain();
    start_fill(0, 16'h3456);
    b = 0;
    while (n_wr[0] < 5 * 8 + 5 && b < 50) begin
      step();
      b++;
    end
    chk("abort_wait_timeout", b < 50, 1'b1);
    rst = 1;
    iq.delete();
    wq.delete();
    bq.delete();
    exp_tag[0]--;
    step();
    check_idle(0);
    rst = 0;
    step();
    check_idle(0);
    start_fill(0, 16'h3456);
    drain();
    start_fill(1, 16'h0A0A);
    drain();
    start_fill(2, 16'h7FF3);
    drain();
    for (int j = 0; j < 3; j++) begin
      chk("tag_count", n_tag[j], exp_tag[j]);
      check_idle(j);
    end
    chk("queues_empty", iq.size() + wq.size() + bq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
